au_seq: RTL and testbench

Parametrised sequential arithmetic unit that generalises the team's 32-bit AU. It adds a start/busy/done handshake, a signed/unsigned mode, and status flags for overflow and divide-by-zero. It sits behind the datapath's execute stage and performs add, sub, multiply and divide on W-bit operands. Multiply and divide are multi-cycle; add and sub complete in one cycle.

---
 rtl/au_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_au_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_seq.sv
// -----------------------------------------------------------------------------
// au_seq -- sequential arithmetic unit with a start/busy/done handshake.
//
// Add and sub finish in one cycle. Multiply (shift-add) and divide (restoring)
// work on operand magnitudes, one bit per cycle. A final fix-up cycle restores
// the signs in signed mode. Results and flags are registered. They change only
// on the cycle that done pulses and then hold until the next done.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset; aborts any operation in flight
//   start  in   request, accepted only while busy=0
//   op     in   2'b00 add, 2'b01 sub, 2'b10 mul, 2'b11 div
//   sgn    in   1: two's-complement operands, 0: unsigned operands
//   a, b   in   W-bit operands, latched on accept
//   busy   out  high while a multiply or divide iterates
//   done   out  one-cycle pulse; results are valid from this cycle on
//   s      out  add/sub result
//   hi     out  product upper half / division remainder
//   lo     out  product lower half / division quotient
//   zero   out  result-is-zero flag
//   ovf    out  overflow (signed overflow, or carry/borrow when unsigned)
//   dz     out  divide-by-zero flag
// -----------------------------------------------------------------------------
module au_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic         sgn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         zero,
  output logic         ovf,
  output logic         dz
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, FIN} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01,
                            OP_MUL = 2'b10, OP_DIV = 2'b11} op_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  op_t            op_r;
  logic           sgn_r;
  logic [W-1:0]   a_r, b_r;
  logic [W-1:0]   m_r;       // multiplicand or divisor magnitude
  logic           a_neg_r;   // dividend sign; sets the remainder sign
  logic           res_neg_r; // operand signs differ
  // Mul: {partial product, remaining multiplier bits}.
  // Div: {partial remainder, remaining dividend bits / quotient bits}.
  logic [2*W-1:0] acc;

  logic           accept;
  logic           a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift, div_diff;
  logic           div_ge;
  logic [2*W-1:0] step_val, fix_val;
  logic [W:0]     as_full;
  logic           as_ovf;
  logic           div_by_zero_r;
  logic           div_ovf_r;

  // In FIN busy is already low, so a start there is accepted. The done for the
  // finishing operation still goes out.
  assign accept = start && (state == IDLE || state == FIN);

  // NOTE: every always_comb output gets a default first. A path that leaves a
  // signal unassigned would infer a latch.
  always_comb begin
    a_neg     = sgn & a[W-1];
    b_neg     = sgn & b[W-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;

    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, m_r} : {(W+1){1'b0}});
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_diff  = div_shift - {1'b0, m_r};
    // The partial remainder stays below the divisor, so bit W is set only when
    // the trial subtraction went negative.
    div_ge    = ~div_diff[W];

    step_val  = acc;
    fix_val   = acc;
    if (op_r == OP_MUL) begin
      step_val = {mul_sum, acc[W-1:1]};
      fix_val  = res_neg_r ? -acc : acc;
    end else begin
      step_val = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), acc[W-2:0], div_ge};
      fix_val  = {(a_neg_r   ? -acc[2*W-1:W] : acc[2*W-1:W]),
                  (res_neg_r ? -acc[W-1:0]   : acc[W-1:0])};
    end

    as_full = (op_r == OP_SUB) ? ({1'b0, a_r} - {1'b0, b_r})
                               : ({1'b0, a_r} + {1'b0, b_r});
    if (sgn_r) begin
      if (op_r == OP_SUB)
        as_ovf = (a_r[W-1] != b_r[W-1]) && (as_full[W-1] != a_r[W-1]);
      else
        as_ovf = (a_r[W-1] == b_r[W-1]) && (as_full[W-1] != a_r[W-1]);
    end else begin
      as_ovf = as_full[W];  // carry-out for add, borrow for sub
    end

    div_by_zero_r = (op_r == OP_DIV) && (b_r == '0);
    div_ovf_r     = sgn_r && (a_r == MOST_NEG) && (b_r == '1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // The datapath registers are cleared together with the visible outputs.
      // A reset in any state then leaves no trace of the aborted operation.
      state     <= IDLE;
      cnt       <= '0;
      op_r      <= OP_ADD;
      sgn_r     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      m_r       <= '0;
      a_neg_r   <= 1'b0;
      res_neg_r <= 1'b0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      s         <= '0;
      hi        <= '0;
      lo        <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        RUN: begin
          acc <= step_val;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= FIX;
        end

        FIX: begin
          acc   <= fix_val;
          busy  <= 1'b0;
          state <= FIN;
        end

        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
          case (op_r)
            OP_ADD, OP_SUB: begin
              s    <= as_full[W-1:0];
              zero <= (as_full[W-1:0] == '0);
              ovf  <= as_ovf;
              dz   <= 1'b0;
            end
            OP_MUL: begin
              {hi, lo} <= acc;
              zero     <= (acc == '0);
              ovf      <= 1'b0;
              dz       <= 1'b0;
            end
            default: begin
              if (div_by_zero_r) begin
                hi   <= a_r;
                lo   <= '1;
                zero <= 1'b0;
                ovf  <= 1'b0;
                dz   <= 1'b1;
              end else begin
                // The signed most-negative / -1 case already yields quotient
                // MOST_NEG and remainder 0 after the fix-up. Only the flag is
                // added here.
                {hi, lo} <= acc;
                zero     <= (acc[W-1:0] == '0);
                ovf      <= div_ovf_r;
                dz       <= 1'b0;
              end
            end
          endcase
        end

        default: ;  // IDLE: wait for an accepted start
      endcase

      // Accept comes last so that it overrides the FIN -> IDLE step.
      if (accept) begin
        op_r      <= op_t'(op);
        sgn_r     <= sgn;
        a_r       <= a;
        b_r       <= b;
        a_neg_r   <= a_neg;
        res_neg_r <= a_neg ^ b_neg;
        cnt       <= '0;
        if (op == OP_MUL) begin
          m_r   <= a_mag;
          acc   <= {{W{1'b0}}, b_mag};
          busy  <= 1'b1;
          state <= RUN;
        end else if (op == OP_DIV && b != '0) begin
          m_r   <= b_mag;
          acc   <= {{W{1'b0}}, a_mag};
          busy  <= 1'b1;
          state <= RUN;
        end else begin
          state <= FIN;
        end
      end
    end
  end

endmodule

// File: tb/tb_au_seq.sv
// -----------------------------------------------------------------------------
// tb_au_seq -- directed self-checking bench for au_seq with W=32.
// Inputs change 1 ns after a rising edge, and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_au_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, sgn;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, zero, ovf, dz;
  logic [W-1:0] s, hi, lo;

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc;
  logic bsy_seen;
  logic done_seen;

  au_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .s(s), .hi(hi), .lo(lo),
    .zero(zero), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  // Present a request for one edge, then scramble the inputs so that a design
  // that fails to latch its operands shows up.
  task automatic do_start(input logic [1:0] o, input logic sg,
                          input logic [W-1:0] aa, input logic [W-1:0] bb);
    start = 1'b1; op = o; sgn = sg; a = aa; b = bb;
    @(posedge clk); #1;
    start = 1'b0; op = 2'b01; sgn = ~sg; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
  endtask

  // Count edges from the accept edge until done is seen, within a budget.
  task automatic wait_done(input int max, output int cycles, output logic busy_hit);
    bit fin;
    fin = 0; cycles = 0; busy_hit = 1'b0;
    while (!fin) begin
      if (busy === 1'b1) busy_hit = 1'b1;
      @(posedge clk); #1;
      cycles++;
      if (done === 1'b1 || cycles > max) fin = 1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; op = 2'b00; sgn = 1'b0; a = 32'd1; b = 32'd2;
    @(posedge clk); @(posedge clk); #1;
    n_total++;
    if ({busy, done, zero, ovf, dz} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {busy, done, zero, ovf, dz});
    else n_pass++;
    n_total++;
    if ({s, hi, lo} !== 96'h0)
      $display("FAIL reset_data: got s=%h hi=%h lo=%h want all 0", s, hi, lo);
    else n_pass++;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (done !== 1'b0) $display("FAIL reset_priority: done=%b want 0", done);
    else n_pass++;
  endtask

  task automatic test_addsub;
    do_start(2'b00, 1'b0, 32'd3, 32'd7);
    wait_done(5, cyc, bsy_seen);
    n_total++;
    if (cyc !== 1) $display("FAIL add_latency: got %0d want 1", cyc); else n_pass++;
    n_total++;
    if ({s, zero, ovf} !== {32'd10, 1'b0, 1'b0})
      $display("FAIL add_3_7: got s=%h z=%b o=%b want s=0000000a z=0 o=0", s, zero, ovf);
    else n_pass++;

    do_start(2'b01, 1'b0, 32'd5, 32'd5);
    wait_done(5, cyc, bsy_seen);
    n_total++;
    if ({s, zero, ovf} !== {32'd0, 1'b1, 1'b0})
      $display("FAIL sub_5_5: got s=%h z=%b o=%b want s=0 z=1 o=0", s, zero, ovf);
    else n_pass++;

    do_start(2'b00, 1'b1, 32'h7FFF_FFFF, 32'd1);
    wait_done(5, cyc, bsy_seen);
    n_total++;
    if ({s, zero, ovf} !== {32'h8000_0000, 1'b0, 1'b1})
      $display("FAIL add_signed_ovf: got s=%h z=%b o=%b want s=80000000 z=0 o=1", s, zero, ovf);
    else n_pass++;

    do_start(2'b01, 1'b0, 32'd0, 32'd1);
    wait_done(5, cyc, bsy_seen);
    n_total++;
    if ({s, ovf, dz} !== {32'hFFFF_FFFF, 1'b1, 1'b0})
      $display("FAIL sub_borrow: got s=%h o=%b dz=%b want s=ffffffff o=1 dz=0", s, ovf, dz);
    else n_pass++;
    n_total++;
    if ({hi, lo} !== 64'h0)
      $display("FAIL addsub_hilo_hold: got hi=%h lo=%h want 0", hi, lo);
    else n_pass++;
  endtask

  task automatic test_mul;
    do_start(2'b10, 1'b0, 32'd7, 32'd21);
    wait_done(40, cyc, bsy_seen);
    n_total++;
    if (cyc !== 34) $display("FAIL mul_latency: got %0d want 34", cyc); else n_pass++;
    n_total++;
    if (bsy_seen !== 1'b1 || busy !== 1'b0)
      $display("FAIL mul_busy: seen=%b at_done=%b want 1 0", bsy_seen, busy);
    else n_pass++;
    n_total++;
    if ({hi, lo, ovf, zero} !== {32'd0, 32'd147, 1'b0, 1'b0})
      $display("FAIL mul_7_21: got hi=%h lo=%h o=%b z=%b want 0 93 0 0", hi, lo, ovf, zero);
    else n_pass++;
    n_total++;
    if (s !== 32'hFFFF_FFFF) $display("FAIL mul_s_hold: got %h want ffffffff", s);
    else n_pass++;

    do_start(2'b10, 1'b1, 32'hFFFF_FFFD, 32'd7);
    wait_done(40, cyc, bsy_seen);
    n_total++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB)
      $display("FAIL mul_signed: got hi=%h lo=%h want ffffffff ffffffeb", hi, lo);
    else n_pass++;

    do_start(2'b10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(40, cyc, bsy_seen);
    n_total++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001)
      $display("FAIL mul_max: got hi=%h lo=%h want fffffffe 00000001", hi, lo);
    else n_pass++;

    do_start(2'b10, 1'b0, 32'd0, 32'd5);
    wait_done(40, cyc, bsy_seen);
    n_total++;
    if ({hi, lo, zero} !== {64'h0, 1'b1})
      $display("FAIL mul_zero: got hi=%h lo=%h z=%b want 0 0 1", hi, lo, zero);
    else n_pass++;
  endtask

  task automatic test_div;
    do_start(2'b11, 1'b0, 32'd100, 32'd5);
    wait_done(40, cyc, bsy_seen);
    n_total++;
    if (cyc !== 34) $display("FAIL div_latency: got %0d want 34", cyc); else n_pass++;
    n_total++;
    if ({hi, lo, dz, ovf} !== {32'd0, 32'd20, 1'b0, 1'b0})
      $display("FAIL div_100_5: got hi=%h lo=%h dz=%b o=%b want 0 14 0 0", hi, lo, dz, ovf);
    else n_pass++;

    do_start(2'b11, 1'b0, 32'd10, 32'd10);
    wait_done(40, cyc, bsy_seen);
    n_total++;
    if ({hi, lo} !== {32'd0, 32'd1})
      $display("FAIL div_10_10: got hi=%h lo=%h want 0 1", hi, lo);
    else n_pass++;

    do_start(2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(40, cyc, bsy_seen);
    n_total++;
    if ({hi, lo, zero} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0})
      $display("FAIL div_signed: got hi=%h lo=%h z=%b want ffffffff fffffffd 0", hi, lo, zero);
    else n_pass++;

    do_start(2'b11, 1'b0, 32'd3, 32'd7);
    wait_done(40, cyc, bsy_seen);
    n_total++;
    if ({hi, lo, zero} !== {32'd3, 32'd0, 1'b1})
      $display("FAIL div_3_7: got hi=%h lo=%h z=%b want 3 0 1", hi, lo, zero);
    else n_pass++;

    do_start(2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(40, cyc, bsy_seen);
    n_total++;
    if ({hi, lo, ovf} !== {32'd0, 32'h8000_0000, 1'b1})
      $display("FAIL div_min_neg1: got hi=%h lo=%h o=%b want 0 80000000 1", hi, lo, ovf);
    else n_pass++;
  endtask

  task automatic test_div_zero;
    do_start(2'b11, 1'b0, 32'd9, 32'd0);
    wait_done(40, cyc, bsy_seen);
    n_total++;
    if (cyc !== 1 || bsy_seen !== 1'b0)
      $display("FAIL dz_timing: got lat=%0d busy=%b want 1 0", cyc, bsy_seen);
    else n_pass++;
    n_total++;
    if ({hi, lo, dz, ovf, zero} !== {32'd9, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0})
      $display("FAIL dz_result: got hi=%h lo=%h dz=%b o=%b z=%b want 9 ffffffff 1 0 0",
               hi, lo, dz, ovf, zero);
    else n_pass++;

    do_start(2'b00, 1'b0, 32'd1, 32'd1);
    wait_done(5, cyc, bsy_seen);
    n_total++;
    if ({s, dz} !== {32'd2, 1'b0})
      $display("FAIL dz_clear: got s=%h dz=%b want 2 0", s, dz);
    else n_pass++;
  endtask

  task automatic test_drop;
    do_start(2'b10, 1'b0, 32'd7, 32'd21);
    repeat (5) begin @(posedge clk); #1; end
    start = 1'b1; op = 2'b00; sgn = 1'b0; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, cyc, bsy_seen);
    n_total++;
    if (cyc + 6 !== 34) $display("FAIL drop_latency: got %0d want 34", cyc + 6);
    else n_pass++;
    n_total++;
    if ({hi, lo, s} !== {32'd0, 32'd147, 32'd2})
      $display("FAIL drop_result: got hi=%h lo=%h s=%h want 0 93 2", hi, lo, s);
    else n_pass++;
    done_seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (done === 1'b1) done_seen = 1'b1; end
    n_total++;
    if (done_seen !== 1'b0) $display("FAIL drop_no_extra_done: got 1 want 0");
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    do_start(2'b00, 1'b0, 32'd2, 32'd3);
    wait_done(5, cyc, bsy_seen);
    n_total++;
    if (s !== 32'd5) $display("FAIL b2b_first: got %h want 5", s); else n_pass++;
    do_start(2'b00, 1'b0, 32'd10, 32'd20);
    wait_done(5, cyc, bsy_seen);
    n_total++;
    if (cyc !== 1 || s !== 32'd30)
      $display("FAIL b2b_second: got lat=%0d s=%h want 1 1e", cyc, s);
    else n_pass++;
    do_start(2'b10, 1'b0, 32'd6, 32'd7);
    wait_done(40, cyc, bsy_seen);
    n_total++;
    if (cyc !== 34 || lo !== 32'd42)
      $display("FAIL b2b_mul: got lat=%0d lo=%h want 34 2a", cyc, lo);
    else n_pass++;
  endtask

  task automatic test_reset_abort;
    do_start(2'b10, 1'b0, 32'd7, 32'd21);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++;
    if ({busy, done, zero, ovf, dz, s, hi, lo} !== 101'h0)
      $display("FAIL abort_clear: got busy=%b done=%b s=%h hi=%h lo=%h want all 0",
               busy, done, s, hi, lo);
    else n_pass++;
    done_seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) done_seen = 1'b1; end
    n_total++;
    if (done_seen !== 1'b0) $display("FAIL abort_no_done: got 1 want 0");
    else n_pass++;
    do_start(2'b00, 1'b0, 32'd4, 32'd5);
    wait_done(5, cyc, bsy_seen);
    n_total++;
    if (cyc !== 1 || s !== 32'd9)
      $display("FAIL abort_recover: got lat=%0d s=%h want 1 9", cyc, s);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; sgn = 1'b0; a = '0; b = '0;
    #1;
    test_reset;
    test_addsub;
    test_mul;
    test_div;
    test_div_zero;
    test_drop;
    test_back_to_back;
    test_reset_abort;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
